// File: rtl/spi_resp_pkg.sv
// Shared types and default sizing for the SPI word responder.
// Pure declarations; no latency or flow control of its own.
package spi_resp_pkg;

  localparam int DATA_W_DEF      = 16;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-flop synchronizer for an asynchronous pin plus one-cycle rise/fall strobes.
// Strobes appear STAGES cycles after the pin edge; no backpressure.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_l,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~prev;
  assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_word_responder.sv
// SPI mode-0 responder serving words from a single-entry holding register; SDO updates SYNC_STAGES+1 clk after a pin edge.
// tx_ready drops while the holding register is full; SPI_RESP_SDO_TRISTATE_EN floats SDO while idle.
module spi_word_responder
  import spi_resp_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              CS,
  input  logic              SCLK,
  output logic              SDO,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic cs_rise, cs_fall, sclk_rise, sclk_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst_l(rst_l),
    .din  (CS),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst_l(rst_l),
    .din  (SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shift_q, hold_q, last_q, load_word;
  logic [CNT_W-1:0]  cnt_q;
  logic              hold_full, accept;
  logic              load, shift_en, cnt_inc, done_set;
  logic              sdo_bit;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    cnt_inc   = 1'b0;
    done_set  = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // the reader samples on the rising edge, so the last rise ends the frame
        if (sclk_rise) begin
          cnt_inc = 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            done_set  = 1'b1;
            state_nxt = TAIL;
          end
        end
        if (sclk_fall && (cnt_q < CNT_W'(DATA_W))) shift_en = 1'b1;
      end
      TAIL:    state_nxt = TAIL;
      default: state_nxt = IDLE;
    endcase
    if (cs_rise) begin
      state_nxt = IDLE;
      done_set  = 1'b0;
    end
  end

  assign accept    = tx_valid & ~hold_full;
  assign load_word = hold_full ? hold_q : last_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      shift_q    <= '0;
      hold_q     <= '0;
      last_q     <= '0;
      hold_full  <= 1'b0;
      cnt_q      <= '0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= done_set;
      underrun   <= load & ~hold_full;
      if (load) begin
        shift_q <= load_word;
        last_q  <= load_word;
        cnt_q   <= '0;
      end else begin
        if (shift_en) shift_q <= {shift_q[DATA_W-2:0], 1'b0};
        if (cnt_inc)  cnt_q   <= cnt_q + 1'b1;
      end
      // accept only happens when empty, so it never collides with draining a full register
      if (accept) begin
        hold_q    <= tx_data;
        hold_full <= 1'b1;
      end else if (load && hold_full) begin
        hold_full <= 1'b0;
      end
    end
  end

  assign tx_ready = ~hold_full;
  assign busy     = (state != IDLE);
  assign sdo_bit  = (state == SHIFT) ? shift_q[DATA_W-1] : 1'b0;

`ifdef SPI_RESP_SDO_TRISTATE_EN
  assign SDO = (state == IDLE) ? 1'bz : sdo_bit;
`else
  assign SDO = sdo_bit;
`endif

endmodule

// File: tb/tb_spi_word_responder.sv
// Bench for spi_word_responder: an SPI mode-0 reader plus a word-level model of the holding register.
module tb_spi_word_responder;

  localparam int DW   = 16;
  localparam int SS   = 2;
  localparam int HALF = 10;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          CS = 1'b1;
  logic          SCLK = 1'b0;
  logic          SDO;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, busy, frame_done, underrun;

  spi_word_responder #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .CS        (CS),
    .SCLK      (SCLK),
    .SDO       (SDO),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .frame_done(frame_done),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: holding register as a queue, last word sent, expected event counts
  logic [DW-1:0] hold_m[$];
  logic [DW-1:0] last_m;
  logic [DW-1:0] exp_q[$];
  int            exp_done = 0, exp_und = 0;
  int            dut_done = 0, dut_und = 0;
  logic [DW-1:0] rx_word;
  logic          sdo_idle;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_l) begin
      if (frame_done === 1'b1) begin
        dut_done++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL frame_done_unexpected: got pulse expected none (rx %h)", rx_word);
        end else begin
          check("frame_word", {16'h0, rx_word}, {16'h0, exp_q.pop_front()});
        end
      end
      if (underrun === 1'b1) dut_und++;
    end
  end

  task automatic model_start(input bit complete);
    logic [DW-1:0] w;
    if (hold_m.size() != 0) begin
      w = hold_m.pop_front();
    end else begin
      w = last_m;
      exp_und++;
    end
    last_m = w;
    if (complete) begin
      exp_q.push_back(w);
      exp_done++;
    end
  endtask

  task automatic write_word(input logic [DW-1:0] w);
    bit ok = 1'b0;
    @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (tx_ready === 1'b1) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    if (ok) hold_m.push_back(w);
    else begin
      n_checks++;
      n_fail++;
      $display("FAIL write_timeout: tx_ready got 0 expected 1 within budget");
    end
  endtask

  // nbits rising edges in one CS window; rst_at >= 0 pulses reset before that bit
  task automatic do_frame(input int nbits, input int rst_at);
    model_start(nbits >= DW && rst_at < 0);
    @(negedge clk);
    rx_word = '0;
    CS = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst_l = 1'b0;
        #1;
        check("rst_sdo", {31'h0, SDO}, {31'h0, sdo_idle});
        check("rst_tx_ready", {31'h0, tx_ready}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_frame_done", {31'h0, frame_done}, 32'h0);
        check("rst_underrun", {31'h0, underrun}, 32'h0);
        hold_m.delete();
        last_m = '0;
        CS = 1'b1;
        SCLK = 1'b0;
        repeat (4) @(negedge clk);
        rst_l = 1'b1;
        repeat (4) @(negedge clk);
        return;
      end
      if (i < DW) rx_word = {rx_word[DW-2:0], SDO};
      else check("tail_bit", {31'h0, SDO}, 32'h0);
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    CS = 1'b1;
    repeat (HALF) @(negedge clk);
    check("done_count", dut_done, exp_done);
    check("underrun_count", dut_und, exp_und);
    check("tx_ready_after", {31'h0, tx_ready}, {31'h0, hold_m.size() == 0});
    check("busy_after", {31'h0, busy}, 32'h0);
  endtask

  initial begin
`ifdef SPI_RESP_SDO_TRISTATE_EN
    sdo_idle = 1'bz;
`else
    sdo_idle = 1'b0;
`endif
    last_m = '0;
    repeat (3) @(negedge clk);
    check("reset_sdo", {31'h0, SDO}, {31'h0, sdo_idle});
    check("reset_tx_ready", {31'h0, tx_ready}, 32'h1);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_frame_done", {31'h0, frame_done}, 32'h0);
    check("reset_underrun", {31'h0, underrun}, 32'h0);
    rst_l = 1'b1;
    repeat (4) @(negedge clk);

    write_word(16'hA5C3);
    check("ready_while_full", {31'h0, tx_ready}, 32'h0);
    do_frame(16, -1);
    do_frame(16, -1);

    write_word(DW'($urandom));
    do_frame(7, -1);
    write_word(16'h1234);
    do_frame(16, -1);

    write_word(16'h0F0F);
    fork
      do_frame(16, -1);
      begin
        repeat (SS + 1) @(negedge clk);
        write_word(16'hBEEF);
      end
    join
    do_frame(16, -1);

    write_word(16'hFFFF);
    do_frame(20, -1);

    for (int k = 0; k < 8; k++) begin
      int pick;
      if ($urandom_range(0, 1) == 1) write_word(DW'($urandom));
      pick = $urandom_range(0, 3);
      if (pick == 0)      do_frame($urandom_range(1, 15), -1);
      else if (pick == 1) do_frame(18, -1);
      else                do_frame(16, -1);
    end

    write_word(DW'($urandom));
    do_frame(16, 5);
    check("post_reset_done_count", dut_done, exp_done);
    check("post_reset_sdo", {31'h0, SDO}, {31'h0, sdo_idle});
    exp_done = dut_done;
    exp_und  = dut_und;
    write_word(DW'($urandom));
    do_frame(16, -1);
    do_frame(16, -1);

    repeat (20) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_word_responder.md
# spi_word_responder

SPI responder (slave) that serves parallel data words to an SPI reader over CS/SCLK/SDO, mode 0 (CPOL=0, CPHA=0), MSB first. It stands in for an off-board SPI sensor/ADC, allowing our SPI read path to be looped back on-chip or run against an emulated peripheral. A single-entry holding register with a valid/ready handshake accepts words from application logic; CS and SCLK are oversampled in the system clock domain.

## Interface
- DATA_W, 16: bits per frame; also holding/shift register width.
- SYNC_STAGES, 2: flops in each CS/SCLK synchronizer (≥2).
- clk  in  1  system clock; all logic on rising edge.
- rst_l  in  1  asynchronous, active-low reset.
- CS  in  1  chip select from reader, active low, asynchronous to clk.
- SCLK  in  1  serial clock from reader, idle low, asynchronous to clk.
- SDO  out  1  serial data to reader.
- tx_data  in  DATA_W  word to be sent in a later frame.
- tx_valid  in  1  tx_data valid; accepted when tx_valid & tx_ready.
- tx_ready  out  1  holding register empty.
- busy  out  1  frame in progress (state ≠ IDLE).
- frame_done  out  1  one-cycle pulse: DATA_W bits fully clocked out.
- underrun  out  1  one-cycle pulse: frame started with holding register empty.

## Operation
- CS and SCLK pass through SYNC_STAGES flops; reset values CS=1, SCLK=0. Edge detectors produce cs_fall, cs_rise, sclk_rise, sclk_fall (one-cycle strobes).
- FSM states: IDLE, SHIFT, TAIL.
- IDLE: on cs_fall, load shift register from holding register (if full; clear holding) or from last transmitted word (if empty; pulse underrun). Clear bit counter; SDO = shift MSB; go to SHIFT.
- SHIFT: sclk_rise increments bit counter (reader samples on this edge). On sclk_fall, if counter < DATA_W, shift left, SDO = new MSB. When counter reaches DATA_W, pulse frame_done; go to TAIL.
- TAIL: SDO = 0; ignore SCLK; wait for cs_rise.
- cs_rise in any state → IDLE. A cs_rise in SHIFT before DATA_W rising edges aborts: no frame_done, and the partial word is not re-queued.
- Holding register: accepted on tx_valid & tx_ready; tx_ready = ~holding_full. If accept and cs_fall load occur in the same cycle, the load uses pre-cycle holding contents; the accepted word stays in holding for the next frame.
- "Last transmitted word" resets to 0; it is updated at every load.
- SCLK edges while in IDLE are ignored.

## Timing
- Reset values: SDO 0 (Z under macro), tx_ready 1, busy 0, frame_done 0, underrun 0, state IDLE, holding empty.
- Pin-to-action latency: SYNC_STAGES+1 clk cycles from a CS/SCLK pin edge to SDO update or strobe.
- Constraint: SCLK high and low phases each ≥ SYNC_STAGES+2 clk cycles; CS fall to first SCLK rise ≥ SYNC_STAGES+2 clk cycles.
- frame_done is asserted in the cycle after the DATA_W-th sclk_rise is detected; underrun is asserted in the cycle after cs_fall is detected.
- Reset asserted mid-frame: everything returns to reset values immediately; the reader receives garbage for the rest of that frame.

## Configuration
- SPI_RESP_SDO_TRISTATE_EN defined: SDO = 1'bz whenever state is IDLE (CS deasserted), including during reset; shared-bus use.
- Not defined: SDO driven 0 in IDLE and during reset.

## Structure
- Package spi_resp_pkg: state enum (IDLE, SHIFT, TAIL), default DATA_W and SYNC_STAGES constants.
- Sub-module spi_sync_edge: N-stage synchronizer with a reset-value parameter plus rise/fall strobes; instantiated for CS and SCLK.

## Test plan
- Load 0xA5C3, then a 16-clock mode-0 frame at 10 clk/half-period: reader samples 0xA5C3; frame_done pulses once; tx_ready returns high at CS fall.
- Two frames with no second write: frame 2 returns 0xA5C3 and underrun pulses once; frame_done pulses for both frames.
- Abort: CS rises after 7 SCLK rises → no frame_done, busy drops; the next frame sends the newly queued 0x1234 intact.
- tx_valid with 0xBEEF in the same cycle as cs_fall detect, holding already 0x0F0F: frame sends 0x0F0F; the next frame sends 0xBEEF.
- 20 SCLK pulses in one CS window with 0xFFFF: bits 17–20 read 0; frame_done pulses exactly once.
- rst_l pulsed low mid-frame: outputs return to reset values asynchronously. With the macro defined, SDO is Z while CS is high; without it, SDO is 0.
